cp0_nest_ctrl: RTL

CP0_NEST_CTRL -- requirements
Module: cp0_nest_ctrl

---
 rtl/cp0_nest_ctrl_pkg.sv | 21 ++
 rtl/cp0_nest_ctrl_nest_stack.sv | 89 ++++++++
 rtl/cp0_nest_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cp0_nest_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cp0_nest_ctrl_pkg
// Shared definitions for the nested-exception Status save/restore controller:
// FSM state encodings, decision constants TAKEN/UNTAKEN and datapath widths.
// No ports (package).
// -----------------------------------------------------------------------------
package cp0_nest_ctrl_pkg;

  localparam int unsigned STATUS_W = 32;
  localparam int unsigned DEPTH_W  = 4;

  localparam logic TAKEN   = 1'b1;
  localparam logic UNTAKEN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SAVE    = 2'b01,
    ST_RESTORE = 2'b10
  } nest_state_e;

endpackage

// File: rtl/cp0_nest_ctrl_nest_stack.sv
// -----------------------------------------------------------------------------
// nest_stack
// LIFO of saved Status words. Entry 0 is the oldest, entry depth-1 the top.
// A push while full drops entry 0, shifts everything down one slot and writes
// the new word at the top, leaving the count at DEPTH.
// Storage is intentionally not reset; only the count is.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push_i, data_i    push request and word to store
//   pop_i             pop request (top_o is the word being popped)
//   top_o             current top-of-stack word (0 when empty)
//   depth_o           number of valid entries
//   full_o, empty_o   count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module nest_stack
  import cp0_nest_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [STATUS_W-1:0] data_i,
  output logic [STATUS_W-1:0] top_o,
  output logic [DEPTH_W-1:0]  depth_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  logic [STATUS_W-1:0] mem_q [DEPTH];
  logic [DEPTH_W-1:0]  depth_q;
  logic [DEPTH_W-1:0]  depth_d;

  assign full_o  = (depth_q == DEPTH_MAX);
  assign empty_o = (depth_q == 4'd0);
  assign depth_o = depth_q;

  // Next count: a full push saturates, an empty pop is ignored.
  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + 4'd1;
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - 4'd1;
    end else begin
      depth_d = depth_q;
    end
  end

  // Top-of-stack read mux, written as a compare loop to avoid a wide index.
  always_comb begin
    top_o = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((DEPTH_W'(i) + 4'd1) == depth_q) begin
        top_o = mem_q[i];
      end else begin
        top_o = top_o;
      end
    end
  end

  // Entry count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= 4'd0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage array: normal push writes slot depth, full push shift-drops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push_i && full_o) begin
        if (i == int'(DEPTH) - 1) begin
          mem_q[i] <= data_i;
        end else begin
          mem_q[i] <= mem_q[(i + 1) % int'(DEPTH)];
        end
      end else if (push_i && (DEPTH_W'(i) == depth_q)) begin
        mem_q[i] <= data_i;
      end
    end
  end

endmodule

// File: rtl/cp0_nest_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_nest_ctrl
// Saves the CP0 Status register on exception entry and restores it on
// exception return, supporting nested exceptions up to DEPTH levels.
// FSM: IDLE -> SAVE (one cycle) on exc_req, IDLE -> RESTORE (one cycle) on
// eret_req with a non-empty stack. exc_req wins over eret_req; requests are
// ignored while busy.
// Optional feature: define CP0_NEST_OVF_TRAP_EN to add a sticky ovf_trap flag;
// a push when full then leaves the stack untouched instead of dropping the
// oldest entry.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   exc_req         exception entry, save status_in
//   eret_req        exception return, restore last saved Status
//   status_in       current Status value
//   restore_we      one-cycle write strobe to the status unit
//   restore_data    Status value to write back (held until next restore)
//   busy            high in SAVE/RESTORE
//   depth           number of saved entries
//   empty_eret      one-cycle pulse on eret_req with nothing saved
//   ovf_trap        (CP0_NEST_OVF_TRAP_EN only) sticky overflow flag
// -----------------------------------------------------------------------------
module cp0_nest_ctrl
  import cp0_nest_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [STATUS_W-1:0] status_in,
  output logic                restore_we,
  output logic [STATUS_W-1:0] restore_data,
  output logic                busy,
  output logic [DEPTH_W-1:0]  depth,
  output logic                empty_eret
`ifdef CP0_NEST_OVF_TRAP_EN
  ,
  output logic                ovf_trap
`endif
);

  nest_state_e         state_q, state_d;
  logic                take_exc_s, take_eret_s, empty_eret_s;
  logic                push_s, pop_s;
  logic [STATUS_W-1:0] stk_top_s;
  logic                stk_full_s, stk_empty_s;
  logic [STATUS_W-1:0] restore_data_q;
  logic                empty_eret_q;

  nest_stack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (status_in),
    .top_o   (stk_top_s),
    .depth_o (depth),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  // Request arbitration in IDLE: exception entry beats return.
  always_comb begin
    take_exc_s   = UNTAKEN;
    take_eret_s  = UNTAKEN;
    empty_eret_s = UNTAKEN;
    if (state_q == ST_IDLE) begin
      if (exc_req) begin
        take_exc_s = TAKEN;
      end else if (eret_req && stk_empty_s) begin
        empty_eret_s = TAKEN;
      end else if (eret_req) begin
        take_eret_s = TAKEN;
      end else begin
        take_exc_s = UNTAKEN;
      end
    end else begin
      take_exc_s = UNTAKEN;
    end
  end

`ifdef CP0_NEST_OVF_TRAP_EN
  logic ovf_q;

  // A full push only raises the trap; the stack keeps its contents.
  assign push_s   = take_exc_s & ~stk_full_s;
  assign ovf_trap = ovf_q;

  // Sticky overflow flag, cleared by a restore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (take_exc_s && stk_full_s) begin
      ovf_q <= 1'b1;
    end else if (take_eret_s) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q;
    end
  end
`else
  // A full push drops the oldest entry inside the stack.
  assign push_s = take_exc_s;
`endif

  assign pop_s = take_eret_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; SAVE and RESTORE each last exactly one cycle.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (take_exc_s) begin
          state_d = ST_SAVE;
        end else if (take_eret_s) begin
          state_d = ST_RESTORE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE:    state_d = ST_IDLE;
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy       = 1'b0;
    restore_we = 1'b0;
    case (state_q)
      ST_IDLE:    begin busy = 1'b0; restore_we = 1'b0; end
      ST_SAVE:    begin busy = 1'b1; restore_we = 1'b0; end
      ST_RESTORE: begin busy = 1'b1; restore_we = 1'b1; end
      default:    begin busy = 1'b0; restore_we = 1'b0; end
    endcase
  end

  // Restore data is captured from the popped top and held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restore_data_q <= 32'h0;
      empty_eret_q   <= 1'b0;
    end else begin
      restore_data_q <= take_eret_s ? stk_top_s : restore_data_q;
      empty_eret_q   <= empty_eret_s;
    end
  end

  assign restore_data = restore_data_q;
  assign empty_eret   = empty_eret_q;

endmodule
